hbus_sync_fifo: RTL and testbench



---
 rtl/hbus_sync_fifo_pkg.sv | 9 +
 rtl/hbus_fifo_mem.sv | 31 +++
 rtl/hbus_sync_fifo.sv | 72 +++++++
 tb/tb_hbus_sync_fifo.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hbus_sync_fifo_pkg.sv
// hbus_sync_fifo_pkg: shared defaults for the single-clock hyperbus queue FIFO.
//   HBUS_FIFO_DSIZE : default data word width in bits
//   HBUS_FIFO_ASIZE : default address width (depth = 2**ASIZE)
package hbus_sync_fifo_pkg;

    localparam int HBUS_FIFO_DSIZE = 8;
    localparam int HBUS_FIFO_ASIZE = 4;

endpackage

// File: rtl/hbus_fifo_mem.sv
// hbus_fifo_mem: 2**ASIZE x DSIZE storage, synchronous write, asynchronous read.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : combinational read data at raddr_i
// Kept as its own module so it can be replaced by vendor distributed RAM.
module hbus_fifo_mem
    import hbus_sync_fifo_pkg::*;
#(
    parameter int DSIZE = HBUS_FIFO_DSIZE,
    parameter int ASIZE = HBUS_FIFO_ASIZE
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);

    logic [DSIZE-1:0] mem_q [1<<ASIZE];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hbus_sync_fifo.sv
// hbus_sync_fifo: single-clock first-word-fall-through FIFO with full/empty and almost flags.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   winc    : write strobe, accepted when not full
//   wdata   : write data
//   wfull   : FIFO holds 2**ASIZE entries
//   awfull  : FIFO holds at least 2**ASIZE-1 entries
//   rinc    : read strobe, accepted when not empty
//   rdata   : head-of-queue data, valid whenever rempty is low
//   rempty  : FIFO holds no entries
//   arempty : FIFO holds at most one entry
module hbus_sync_fifo
    import hbus_sync_fifo_pkg::*;
#(
    parameter int DSIZE = HBUS_FIFO_DSIZE,
    parameter int ASIZE = HBUS_FIFO_ASIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty
);

    localparam logic [ASIZE:0] DEPTH_M1 = {1'b0, {ASIZE{1'b1}}};
    localparam logic [ASIZE:0] ONE      = {{ASIZE{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ASIZE:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic           wr_en, rd_en;

    assign count   = wptr_q - rptr_q;
    assign rempty  = wptr_q == rptr_q;
    assign wfull   = (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]) && (wptr_q[ASIZE] != rptr_q[ASIZE]);
    assign awfull  = count >= DEPTH_M1;
    assign arempty = count <= ONE;

    // Flags are sampled before the edge, so a full FIFO drops a concurrent
    // write and an empty FIFO ignores a concurrent read.
    assign wr_en  = winc & ~wfull;
    assign rd_en  = rinc & ~rempty;
    assign wptr_d = wr_en ? wptr_q + ONE : wptr_q;
    assign rptr_d = rd_en ? rptr_q + ONE : rptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    hbus_fifo_mem #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) u_mem (
        .clk    (clk),
        .we_i   (wr_en),
        .waddr_i(wptr_q[ASIZE-1:0]),
        .wdata_i(wdata),
        .raddr_i(rptr_q[ASIZE-1:0]),
        .rdata_o(rdata)
    );

endmodule

// File: tb/tb_hbus_sync_fifo.sv
// tb_hbus_sync_fifo: directed and random stimulus against a queue model of the FIFO.
module tb_hbus_sync_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       wfull, awfull, rempty, arempty;

    int         checks = 0;
    int         passed = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    hbus_sync_fifo #(.DSIZE(8), .ASIZE(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .winc   (winc),
        .wdata  (wdata),
        .wfull  (wfull),
        .awfull (awfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty),
        .arempty(arempty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference queue: acceptance decided from occupancy before the edge.
    always @(posedge clk or posedge rst) begin
        bit wa, ra;
        if (rst) q.delete();
        else begin
            wa = winc && (q.size() < DEPTH);
            ra = rinc && (q.size() > 0);
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(wdata);
        end
    end

    always @(negedge clk) begin
        chk("rempty", rempty, q.size() == 0);
        chk("wfull", wfull, q.size() == DEPTH);
        chk("awfull", awfull, q.size() >= DEPTH - 1);
        chk("arempty", arempty, q.size() <= 1);
        if (q.size() != 0) chk("rdata", rdata, q[0]);
    end

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        winc = w;
        rinc = r;
        wdata = d;
        @(posedge clk);
        #2;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    initial begin
        int pushed;
        logic w, r;
        #1 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;

        step(1, 0, 8'hA5);
        chk("fwft_rempty", rempty, 0);
        chk("fwft_rdata", rdata, 8'hA5);
        step(0, 1, 0);
        chk("pop_rempty", rempty, 1);

        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'(i));
            if (i == 13) chk("awfull_14", awfull, 0);
            if (i == 14) begin
                chk("awfull_15", awfull, 1);
                chk("wfull_15", wfull, 0);
            end
            if (i == 15) chk("wfull_16", wfull, 1);
        end
        step(1, 0, 8'hFF);
        chk("drop_wfull", wfull, 1);
        chk("drop_head", rdata, 8'h00);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", rdata, i);
            step(0, 1, 0);
            if (i == 13) chk("arempty_2", arempty, 0);
            if (i == 14) chk("arempty_1", arempty, 1);
            if (i == 15) chk("drain_rempty", rempty, 1);
        end

        for (int i = 0; i < 3; i++) step(1, 0, 8'h10 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            chk("sim_head", rdata, 8'h10 + 8'(i));
            step(1, 1, 8'h13 + 8'(i));
        end
        chk("sim_head_end", rdata, 8'h1A);
        for (int c = 0; c < 40 && !rempty; c++) step(0, 1, 0);

        for (int i = 0; i < 16; i++) step(1, 0, 8'h40 + 8'(i));
        step(1, 1, 8'hEE);
        chk("full_rw_wfull", wfull, 0);
        chk("full_rw_awfull", awfull, 1);
        chk("full_rw_head", rdata, 8'h41);
        for (int c = 0; c < 40 && !rempty; c++) step(0, 1, 0);

        step(1, 1, 8'h77);
        chk("empty_rw_rempty", rempty, 0);
        chk("empty_rw_arempty", arempty, 1);
        chk("empty_rw_rdata", rdata, 8'h77);
        step(0, 1, 0);

        pushed = 0;
        for (int c = 0; c < 3000 && pushed < 100; c++) begin
            w = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 1) == 1);
            if (w && q.size() < DEPTH) pushed++;
            step(w, r, 8'($urandom));
        end
        chk("rand_pushed", pushed, 100);
        for (int c = 0; c < 64 && q.size() > 7; c++) step(0, 1, 0);
        for (int c = 0; c < 64 && q.size() < 7; c++) step(1, 0, 8'($urandom));

        rst = 1'b1;
        #1;
        chk("rst_rempty", rempty, 1);
        chk("rst_arempty", arempty, 1);
        chk("rst_wfull", wfull, 0);
        chk("rst_awfull", awfull, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        step(1, 0, 8'h3C);
        chk("post_rst_rdata", rdata, 8'h3C);
        chk("post_rst_arempty", arempty, 1);
        step(0, 1, 0);
        chk("post_rst_rempty", rempty, 1);

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
